// File: rtl/queue_pkg.sv
// Shared encodings and sprite geometry for the queue player controller
// and the queue sprite renderer.
package queue_pkg;

    localparam int QUEUE_SPRITE_W = 44;
    localparam int QUEUE_SPRITE_H = 50;

    typedef enum logic {
        QUEUE_INITIAL = 1'b0,
        QUEUE_PLAYING = 1'b1
    } queue_state_t;

    typedef enum logic {
        QUEUE_LEFT  = 1'b0,
        QUEUE_RIGHT = 1'b1
    } queue_dir_t;

    typedef enum logic {
        V_GROUNDED = 1'b0,
        V_AIR      = 1'b1
    } queue_vstate_t;

endpackage

// File: rtl/queue_jump_physics.sv
// Vertical motion of the queue sprite: jump launch, per-tick velocity
// integration with gravity, landing on the ground line and head clamp.
//
// state      | meaning
// V_GROUNDED | sprite resting at GROUND_Y, waiting for a jump on a step
// V_AIR      | jump in progress, posY integrates vy once per step
module queue_jump_physics
    import queue_pkg::*;
#(
    parameter int GROUND_Y = 400,
    parameter int JUMP_V0  = 12,
    parameter int GRAVITY  = 1,
    parameter int SPRITE_H = QUEUE_SPRITE_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    input  logic       jump_i,
    output logic [8:0] pos_y_o,
    output logic       airborne_o
);

    localparam logic signed [9:0] GROUND_S = 10'(GROUND_Y);
    localparam logic signed [9:0] TOP_S    = 10'(SPRITE_H / 2);

    queue_vstate_t     vs_q, vs_d;
    logic signed [6:0] vy_q, vy_d;
    logic [8:0]        posy_q, posy_d;
    logic signed [9:0] ny;

    // Vertical state, velocity and position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q   <= V_GROUNDED;
            vy_q   <= '0;
            posy_q <= 9'(GROUND_Y);
        end else begin
            vs_q   <= vs_d;
            vy_q   <= vy_d;
            posy_q <= posy_d;
        end
    end

    // Next vertical state: launch from ground, integrate in air, clamp at ground and top
    always_comb begin
        vs_d   = vs_q;
        vy_d   = vy_q;
        posy_d = posy_q;
        ny     = $signed({1'b0, posy_q}) - $signed({{3{vy_q[6]}}, vy_q});
        if (step_i) begin
            case (vs_q)
                V_GROUNDED: begin
                    if (jump_i) begin
                        posy_d = 9'(GROUND_Y - JUMP_V0);
                        vy_d   = 7'(JUMP_V0 - GRAVITY);
                        vs_d   = V_AIR;
                    end
                end
                V_AIR: begin
                    vy_d = vy_q - 7'(GRAVITY);
                    if (ny >= GROUND_S) begin
                        posy_d = 9'(GROUND_Y);
                        vy_d   = '0;
                        vs_d   = V_GROUNDED;
                    end else if (ny < TOP_S) begin
                        // Head hit the top: stop rising, fall starts on the next step
                        posy_d = 9'(SPRITE_H / 2);
                        vy_d   = '0;
                    end else begin
                        posy_d = ny[8:0];
                    end
                end
                default: vs_d = V_GROUNDED;
            endcase
        end
    end

    assign pos_y_o    = posy_q;
    assign airborne_o = (vs_q == V_AIR);

endmodule

// File: rtl/queue_motion_ctrl.sv
// Player-motion controller for the queue sprite: game start FSM, start
// button edge detect, horizontal step with clamp (or wrap) and facing.
// Vertical motion lives in queue_jump_physics.
// Build option: QUEUE_WRAP_X_EN makes horizontal moves past a bound wrap
// to the opposite bound instead of saturating.
//
// state         | meaning
// QUEUE_INITIAL | waiting for a start press, all motion frozen
// QUEUE_PLAYING | motion updates on every frame tick, left only by reset
module queue_motion_ctrl
    import queue_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SPRITE_W = QUEUE_SPRITE_W,
    parameter int SPRITE_H = QUEUE_SPRITE_H,
    parameter int START_X  = 100,
    parameter int GROUND_Y = 400,
    parameter int STEP_X   = 2,
    parameter int JUMP_V0  = 12,
    parameter int GRAVITY  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] posX,
    output logic [8:0] posY,
    output logic       state,
    output logic       animation_state,
    output logic       airborne
);

    localparam logic signed [10:0] X_MIN  = 11'(SPRITE_W / 2);
    localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - 1 - SPRITE_W / 2);
    localparam logic signed [10:0] STEP_S = 11'(STEP_X);

    queue_state_t      state_q, state_d;
    queue_dir_t        facing_q, facing_d;
    logic              start_q;
    logic [9:0]        posx_q, posx_d;
    logic signed [10:0] nx;
    logic              step;

    assign step = (state_q == QUEUE_PLAYING) && frame_tick;

    // Game state, start edge history, horizontal position and facing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= QUEUE_INITIAL;
            start_q  <= 1'b1;
            posx_q   <= 10'(START_X);
            facing_q <= QUEUE_RIGHT;
        end else begin
            state_q  <= state_d;
            start_q  <= btn_start;
            posx_q   <= posx_d;
            facing_q <= facing_d;
        end
    end

    // Game FSM: a rising start edge in INITIAL begins play
    always_comb begin
        state_d = state_q;
        if (state_q == QUEUE_INITIAL && btn_start && !start_q) begin
            state_d = QUEUE_PLAYING;
        end
    end

    // Horizontal step in signed 11 bits, then clamp or wrap to the visible band
    always_comb begin
        posx_d   = posx_q;
        facing_d = facing_q;
        nx       = $signed({1'b0, posx_q}) + (btn_left ? -STEP_S : STEP_S);
        if (step && (btn_left ^ btn_right)) begin
            facing_d = btn_left ? QUEUE_LEFT : QUEUE_RIGHT;
`ifdef QUEUE_WRAP_X_EN
            if (nx < X_MIN)      posx_d = X_MAX[9:0];
            else if (nx > X_MAX) posx_d = X_MIN[9:0];
            else                 posx_d = nx[9:0];
`else
            if (nx < X_MIN)      posx_d = X_MIN[9:0];
            else if (nx > X_MAX) posx_d = X_MAX[9:0];
            else                 posx_d = nx[9:0];
`endif
        end
    end

    queue_jump_physics #(
        .GROUND_Y (GROUND_Y),
        .JUMP_V0  (JUMP_V0),
        .GRAVITY  (GRAVITY),
        .SPRITE_H (SPRITE_H)
    ) u_jump (
        .clk        (clk),
        .rst        (rst),
        .step_i     (step),
        .jump_i     (btn_jump),
        .pos_y_o    (posY),
        .airborne_o (airborne)
    );

    assign posX            = posx_q;
    assign state           = state_q;
    assign animation_state = facing_q;

endmodule

// File: tb/tb_queue_motion_ctrl.sv
// Self-checking bench for queue_motion_ctrl. A behavioural reference model
// predicts every clock; predictions go through a scoreboard queue and are
// compared against the outputs #1 after the edge.
module tb_queue_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_jump = 1'b0;
    logic [9:0] posX;
    logic [8:0] posY;
    logic       state;
    logic       animation_state;
    logic       airborne;

    int checks = 0;
    int errors = 0;

    logic [21:0] sb[$];
    logic [21:0] exp_v;

    int mx, my, mvy, mair, mface, mstate, mprev;

    queue_motion_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .btn_start       (btn_start),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_jump        (btn_jump),
        .posX            (posX),
        .posY            (posY),
        .state           (state),
        .animation_state (animation_state),
        .airborne        (airborne)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] obs();
        return {posX, posY, state, animation_state, airborne};
    endfunction

    function automatic logic [21:0] model_vec();
        return {10'(mx), 9'(my), 1'(mstate), 1'(mface), 1'(mair)};
    endfunction

    task automatic model_reset();
        mx = 100; my = 400; mvy = 0; mair = 0; mface = 1; mstate = 0; mprev = 1;
    endtask

    // Drive one clock of stimulus, advance the model, push its prediction
    task automatic cyc(input logic t, input logic s, input logic l, input logic r, input logic j);
        int nx, ny;
        frame_tick = t; btn_start = s; btn_left = l; btn_right = r; btn_jump = j;
        if (mstate == 1 && t) begin
            if (l != r) begin
                nx = l ? mx - 2 : mx + 2;
`ifdef QUEUE_WRAP_X_EN
                if (nx < 22) nx = 617;
                else if (nx > 617) nx = 22;
`else
                if (nx < 22) nx = 22;
                else if (nx > 617) nx = 617;
`endif
                mx = nx;
                mface = r ? 1 : 0;
            end
            if (mair == 0) begin
                if (j) begin my = 388; mvy = 11; mair = 1; end
            end else begin
                ny = my - mvy;
                mvy = mvy - 1;
                if (ny >= 400) begin my = 400; mvy = 0; mair = 0; end
                else if (ny < 25) begin my = 25; mvy = 0; end
                else my = ny;
            end
        end
        if (mstate == 0 && s && !mprev) mstate = 1;
        mprev = s;
        sb.push_back(model_vec());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        exp_v = model_vec();
        checks++;
        if (obs() !== exp_v) begin
            errors++; $display("FAIL reset_values: got %h expected %h", obs(), exp_v);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            exp_v = sb.pop_front(); checks++;
            if (obs() !== exp_v) begin
                errors++; $display("FAIL start_held_%0d: got %h expected %h", i, obs(), exp_v);
            end
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin
            errors++; $display("FAIL tick_in_initial: got %h expected %h", obs(), exp_v);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin
            errors++; $display("FAIL start_release: got %h expected %h", obs(), exp_v);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v || state !== 1'b1 || posX !== 10'd100) begin
            errors++; $display("FAIL start_press: got %h expected %h state %b", obs(), exp_v, state);
        end
    endtask

    task automatic test_right();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            exp_v = sb.pop_front(); checks++;
            if (obs() !== exp_v) begin
                errors++; $display("FAIL right_tick_%0d: got %h expected %h", i, obs(), exp_v);
            end
            for (int k = 0; k < 2; k++) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                exp_v = sb.pop_front(); checks++;
                if (obs() !== exp_v) begin
                    errors++; $display("FAIL right_hold_%0d_%0d: got %h expected %h", i, k, obs(), exp_v);
                end
            end
        end
        checks++;
        if (posX !== 10'd110 || animation_state !== 1'b1) begin
            errors++; $display("FAIL right_final: got posX %0d facing %b expected 110 1", posX, animation_state);
        end
    endtask

    task automatic test_jump();
        for (int i = 1; i <= 26; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, (i == 1 || i == 6 || i == 7));
            exp_v = sb.pop_front(); checks++;
            if (obs() !== exp_v) begin
                errors++; $display("FAIL jump_tick_%0d: got %h expected %h", i, obs(), exp_v);
            end
            if (i == 12) begin
                checks++;
                if (posY !== 9'd322 || airborne !== 1'b1) begin
                    errors++; $display("FAIL jump_peak: got posY %0d air %b expected 322 1", posY, airborne);
                end
            end
            if (i == 25) begin
                checks++;
                if (posY !== 9'd400 || airborne !== 1'b0) begin
                    errors++; $display("FAIL jump_land: got posY %0d air %b expected 400 0", posY, airborne);
                end
            end
        end
    endtask

    task automatic test_both();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            exp_v = sb.pop_front(); checks++;
            if (obs() !== exp_v) begin
                errors++; $display("FAIL both_tick_%0d: got %h expected %h", i, obs(), exp_v);
            end
        end
        checks++;
        if (posX !== 10'd110 || animation_state !== 1'b1) begin
            errors++; $display("FAIL both_final: got posX %0d facing %b expected 110 1", posX, animation_state);
        end
    endtask

    task automatic test_left_clamp();
        int want[3];
`ifdef QUEUE_WRAP_X_EN
        want = '{22, 617, 615};
`else
        want = '{22, 22, 22};
`endif
        for (int i = 0; i < 43; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            exp_v = sb.pop_front(); checks++;
            if (obs() !== exp_v) begin
                errors++; $display("FAIL left_walk_%0d: got %h expected %h", i, obs(), exp_v);
            end
        end
        checks++;
        if (posX !== 10'd24 || animation_state !== 1'b0) begin
            errors++; $display("FAIL left_at_24: got posX %0d facing %b expected 24 0", posX, animation_state);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            exp_v = sb.pop_front(); checks++;
            if (obs() !== exp_v || posX !== 10'(want[i])) begin
                errors++; $display("FAIL left_bound_%0d: got posX %0d expected %0d", i, posX, want[i]);
            end
        end
    endtask

    task automatic test_reset_midjump();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, (i == 0));
            exp_v = sb.pop_front(); checks++;
            if (obs() !== exp_v) begin
                errors++; $display("FAIL midjump_tick_%0d: got %h expected %h", i, obs(), exp_v);
            end
        end
        checks++;
        if (posY !== 9'd350 || airborne !== 1'b1) begin
            errors++; $display("FAIL midjump_pos: got posY %0d air %b expected 350 1", posY, airborne);
        end
        rst = 1'b1; frame_tick = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; frame_tick = 1'b0;
        model_reset();
        exp_v = model_vec(); checks++;
        if (obs() !== exp_v || posY !== 9'd400 || posX !== 10'd100 || state !== 1'b0 || airborne !== 1'b0) begin
            errors++; $display("FAIL midjump_reset: got %h expected %h", obs(), exp_v);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_right();
        test_jump();
        test_both();
        test_left_clamp();
        test_reset_midjump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
